mill_rx_ctrl: RTL and testbench

- Receive-side sequencer for the modified Miller decoder. The front end runs at 3.39 MHz, with 32 clocks per 106 kbit/s ETU.
- Arms and disarms the decoder and detects start of frame from the raw pause input.
- Assembles the decoded bit strobes into bytes, checks ISO 14443-A odd parity, detects end of frame by pause-free idle time, and reports frame status to the protocol layer.

---
 rtl/mill_rx_ctrl.sv | 232 +++++++++++++++++++++++
 tb/tb_mill_rx_ctrl.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mill_rx_ctrl.sv
// Receive sequencer for the modified Miller decoder: arms the decoder, finds SOF, packs bytes, flags errors, finds EOF.
// Latency: byte strobe and frame_done are registered and appear one clock after the bit strobe / EOF condition is sampled.
// Backpressure: none; the protocol layer must accept every out_byte_valid strobe as it occurs.
//
// Ports:
//   clk, in_PoR (sync active-low reset)
//   in_rx_arm, in_abort        control from the protocol layer
//   in_pause                   raw carrier pause from the analog front end
//   in_dem_bit(_valid)         decoded bit stream from the Miller decoder
//   out_dem_enable             decoder enable
//   out_byte/out_nbits/out_byte_valid/out_byte_count  assembled data
//   out_parity_err/out_overflow/out_timeout           sticky per-frame status
//   out_busy, out_frame_done   sequencer status
module mill_rx_ctrl #(
  parameter int CLK_PER_ETU = 32,
  parameter int IDLE_ETU    = 2,
  parameter int TIMEOUT_CLK = 4096,
  parameter int MAX_BYTES   = 32
) (
  input  logic       clk,
  input  logic       in_PoR,
  input  logic       in_rx_arm,
  input  logic       in_abort,
  input  logic       in_pause,
  input  logic       in_dem_bit,
  input  logic       in_dem_bit_valid,
  output logic       out_dem_enable,
  output logic [7:0] out_byte,
  output logic [3:0] out_nbits,
  output logic       out_byte_valid,
  output logic [5:0] out_byte_count,
  output logic       out_parity_err,
  output logic       out_overflow,
  output logic       out_timeout,
  output logic       out_busy,
  output logic       out_frame_done
);

  localparam int IDLE_LIM = IDLE_ETU * CLK_PER_ETU;
  localparam int IW       = $clog2(IDLE_LIM) + 1;
  localparam int TW       = $clog2(TIMEOUT_CLK) + 1;

  localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_LIM - 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CLK - 1);
  localparam logic [5:0]    MAX_CNT   = 6'(MAX_BYTES);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_SOF,
    ST_RECEIVE,
    ST_DONE
  } state_e;

  state_e        state_q,    state_d;
  logic          pause_q;
  logic [3:0]    bit_idx_q,  bit_idx_d;
  logic [7:0]    sreg_q,     sreg_d;
  logic [IW-1:0] idle_cnt_q, idle_cnt_d;
  logic [TW-1:0] tmo_cnt_q,  tmo_cnt_d;
  logic          eof_pend_q, eof_pend_d;
  logic [7:0]    byte_q,     byte_d;
  logic [3:0]    nbits_q,    nbits_d;
  logic          byte_vld_q, byte_vld_d;
  logic [5:0]    byte_cnt_q, byte_cnt_d;
  logic          par_err_q,  par_err_d;
  logic          ovf_q,      ovf_d;
  logic          tmo_q,      tmo_d;
  logic          dem_en_q,   dem_en_d;
  logic          done_q,     done_d;

  logic pause_edge;
  logic idle_hit;
  logic eof;

  assign pause_edge = in_pause & ~pause_q;
  assign idle_hit   = ~in_pause & (idle_cnt_q == IDLE_LAST);
  // A bit strobe on the expiry cycle defers EOF by one clock via eof_pend_q.
  assign eof        = idle_hit | eof_pend_q;

  always_comb begin
    state_d    = state_q;
    bit_idx_d  = bit_idx_q;
    sreg_d     = sreg_q;
    idle_cnt_d = idle_cnt_q;
    tmo_cnt_d  = tmo_cnt_q;
    eof_pend_d = eof_pend_q;
    byte_d     = byte_q;
    nbits_d    = nbits_q;
    byte_vld_d = 1'b0;
    byte_cnt_d = byte_cnt_q;
    par_err_d  = par_err_q;
    ovf_d      = ovf_q;
    tmo_d      = tmo_q;

    if (in_abort) begin
      // Abort freezes the datapath: no emit, sticky flags untouched.
      state_d    = ST_IDLE;
      eof_pend_d = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (in_rx_arm) begin
            state_d    = ST_WAIT_SOF;
            bit_idx_d  = '0;
            sreg_d     = '0;
            idle_cnt_d = '0;
            tmo_cnt_d  = '0;
            eof_pend_d = 1'b0;
            byte_cnt_d = '0;
            par_err_d  = 1'b0;
            ovf_d      = 1'b0;
            tmo_d      = 1'b0;
          end
        end

        ST_WAIT_SOF: begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
          if (pause_edge) begin
            state_d    = ST_RECEIVE;
            idle_cnt_d = '0;
          end else if (tmo_cnt_q == TMO_LAST) begin
            tmo_d   = 1'b1;
            state_d = ST_DONE;
          end
        end

        ST_RECEIVE: begin
          idle_cnt_d = in_pause ? '0 : idle_cnt_q + 1'b1;

          // After an overflow every further bit is dropped until EOF.
          if (in_dem_bit_valid && !ovf_q) begin
            if (bit_idx_q == 4'd8) begin
              bit_idx_d = '0;
              sreg_d    = '0;
              if (byte_cnt_q == MAX_CNT) begin
                ovf_d = 1'b1;
              end else begin
                // Odd parity: data plus parity bit must have odd weight.
                if (^{sreg_q, in_dem_bit} == 1'b0) begin
                  par_err_d = 1'b1;
                end
                byte_d     = sreg_q;
                nbits_d    = 4'd8;
                byte_vld_d = 1'b1;
                byte_cnt_d = byte_cnt_q + 1'b1;
              end
            end else begin
              sreg_d[bit_idx_q[2:0]] = in_dem_bit;
              bit_idx_d              = bit_idx_q + 4'd1;
            end
          end

          if (eof) begin
            if (in_dem_bit_valid) begin
              eof_pend_d = 1'b1;
            end else begin
              state_d    = ST_DONE;
              eof_pend_d = 1'b0;
              // Residual (e.g. 7-bit short frame): not counted, no parity.
              if (bit_idx_q != 4'd0) begin
                byte_d     = sreg_q;
                nbits_d    = bit_idx_q;
                byte_vld_d = 1'b1;
              end
            end
          end
        end

        ST_DONE: begin
          state_d = ST_IDLE;
        end

        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    dem_en_d = (state_d == ST_WAIT_SOF) || (state_d == ST_RECEIVE);
    done_d   = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (!in_PoR) begin
      state_q    <= ST_IDLE;
      pause_q    <= 1'b0;
      bit_idx_q  <= '0;
      sreg_q     <= '0;
      idle_cnt_q <= '0;
      tmo_cnt_q  <= '0;
      eof_pend_q <= 1'b0;
      byte_q     <= '0;
      nbits_q    <= '0;
      byte_vld_q <= 1'b0;
      byte_cnt_q <= '0;
      par_err_q  <= 1'b0;
      ovf_q      <= 1'b0;
      tmo_q      <= 1'b0;
      dem_en_q   <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pause_q    <= in_pause;
      bit_idx_q  <= bit_idx_d;
      sreg_q     <= sreg_d;
      idle_cnt_q <= idle_cnt_d;
      tmo_cnt_q  <= tmo_cnt_d;
      eof_pend_q <= eof_pend_d;
      byte_q     <= byte_d;
      nbits_q    <= nbits_d;
      byte_vld_q <= byte_vld_d;
      byte_cnt_q <= byte_cnt_d;
      par_err_q  <= par_err_d;
      ovf_q      <= ovf_d;
      tmo_q      <= tmo_d;
      dem_en_q   <= dem_en_d;
      done_q     <= done_d;
    end
  end

  assign out_dem_enable = dem_en_q;
  assign out_byte       = byte_q;
  assign out_nbits      = nbits_q;
  assign out_byte_valid = byte_vld_q;
  assign out_byte_count = byte_cnt_q;
  assign out_parity_err = par_err_q;
  assign out_overflow   = ovf_q;
  assign out_timeout    = tmo_q;
  assign out_busy       = (state_q != ST_IDLE);
  assign out_frame_done = done_q;

endmodule

// File: tb/tb_mill_rx_ctrl.sv
module tb_mill_rx_ctrl;

  localparam int MAX_BYTES = 32;

  logic       clk = 1'b0;
  logic       in_PoR, in_rx_arm, in_abort, in_pause, in_dem_bit, in_dem_bit_valid;
  logic       out_dem_enable, out_byte_valid, out_parity_err, out_overflow;
  logic       out_timeout, out_busy, out_frame_done;
  logic [7:0] out_byte;
  logic [3:0] out_nbits;
  logic [5:0] out_byte_count;

  int n_cmp = 0;
  int n_err = 0;

  // Observed strobes {nbits, byte} and done pulses, collected on the falling edge.
  logic [11:0] got_q[$];
  int          done_cnt = 0;

  // Stimulus bits of the current frame and the model's expectations.
  logic        tx_bits[$];
  logic [11:0] exp_q[$];
  int          exp_cnt;
  logic        exp_par, exp_ovf;

  always #5 clk = ~clk;

  mill_rx_ctrl dut (
    .clk             (clk),
    .in_PoR          (in_PoR),
    .in_rx_arm       (in_rx_arm),
    .in_abort        (in_abort),
    .in_pause        (in_pause),
    .in_dem_bit      (in_dem_bit),
    .in_dem_bit_valid(in_dem_bit_valid),
    .out_dem_enable  (out_dem_enable),
    .out_byte        (out_byte),
    .out_nbits       (out_nbits),
    .out_byte_valid  (out_byte_valid),
    .out_byte_count  (out_byte_count),
    .out_parity_err  (out_parity_err),
    .out_overflow    (out_overflow),
    .out_timeout     (out_timeout),
    .out_busy        (out_busy),
    .out_frame_done  (out_frame_done)
  );

  always @(negedge clk) begin
    if (out_byte_valid === 1'b1) got_q.push_back({out_nbits, out_byte});
    if (out_frame_done === 1'b1) done_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void push_byte(input logic [7:0] b, input logic p);
    for (int j = 0; j < 8; j++) tx_bits.push_back(b[j]);
    tx_bits.push_back(p);
  endfunction

  // Frame model: 9-bit groups are data+parity, at most MAX_BYTES are emitted,
  // an overflowing group kills the rest of the frame, leftover bits form a residual.
  function automatic void build_model();
    int n, rem;
    logic [7:0] d;
    logic p;
    n = tx_bits.size();
    exp_q.delete();
    exp_cnt = 0;
    exp_par = 1'b0;
    exp_ovf = 1'b0;
    for (int k = 0; k + 9 <= n; k += 9) begin
      if (exp_ovf) break;
      for (int j = 0; j < 8; j++) d[j] = tx_bits[k + j];
      p = tx_bits[k + 8];
      if (exp_cnt == MAX_BYTES) begin
        exp_ovf = 1'b1;
      end else begin
        exp_q.push_back({4'd8, d});
        exp_cnt++;
        if ((^d ^ p) == 1'b0) exp_par = 1'b1;
      end
    end
    rem = n % 9;
    if (!exp_ovf && rem > 0) begin
      d = 8'h00;
      for (int j = 0; j < rem; j++) d[j] = tx_bits[n - rem + j];
      exp_q.push_back({4'(rem), d});
    end
  endfunction

  // Arm, SOF pause, then one bit per 32-clock ETU with a short pause at the
  // start of each ETU. With exact_last the final strobe lands on the clock
  // where the 64-clock pause-free window expires.
  task automatic drive_frame(input bit exact_last);
    int n;
    n = tx_bits.size();
    in_rx_arm = 1'b1; tick(); in_rx_arm = 1'b0;
    repeat (3) tick();
    in_pause = 1'b1; repeat (3) tick(); in_pause = 1'b0; repeat (13) tick();
    for (int i = 0; i < n; i++) begin
      if (exact_last && i == n - 1) begin
        in_pause = 1'b1; tick(); in_pause = 1'b0;
        repeat (63) tick();
        in_dem_bit = tx_bits[i]; in_dem_bit_valid = 1'b1; tick(); in_dem_bit_valid = 1'b0;
      end else begin
        in_pause = 1'b1; repeat (3) tick(); in_pause = 1'b0; repeat (13) tick();
        in_dem_bit = tx_bits[i]; in_dem_bit_valid = 1'b1; tick(); in_dem_bit_valid = 1'b0;
        repeat (15) tick();
      end
    end
  endtask

  task automatic wait_done(input int budget, output bit seen, output int waited);
    seen = 1'b0;
    waited = 0;
    while (!seen && waited < budget) begin
      tick();
      waited++;
      if (out_frame_done === 1'b1) seen = 1'b1;
    end
  endtask

  task automatic test_frame(input string nm, input bit exact_last);
    int base, d0, w;
    bit seen;
    build_model();
    base = got_q.size();
    d0 = done_cnt;
    drive_frame(exact_last);
    wait_done(400, seen, w);
    tick(); tick();
    n_cmp++; if (!seen) begin n_err++; $display("FAIL %s_done: frame_done not seen within %0d clocks", nm, w); end
    n_cmp++; if (done_cnt - d0 != 1) begin n_err++; $display("FAIL %s_done_pulses: got %0d want 1", nm, done_cnt - d0); end
    n_cmp++; if (got_q.size() - base != exp_q.size()) begin n_err++; $display("FAIL %s_nstrobes: got %0d want %0d", nm, got_q.size() - base, exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      if (base + i < got_q.size()) begin
        n_cmp++;
        if (got_q[base + i] !== exp_q[i]) begin n_err++; $display("FAIL %s_byte%0d: got nbits/byte %h want %h", nm, i, got_q[base + i], exp_q[i]); end
      end
    end
    n_cmp++; if (out_byte_count !== 6'(exp_cnt)) begin n_err++; $display("FAIL %s_count: got %0d want %0d", nm, out_byte_count, exp_cnt); end
    n_cmp++; if (out_parity_err !== exp_par) begin n_err++; $display("FAIL %s_parity: got %b want %b", nm, out_parity_err, exp_par); end
    n_cmp++; if (out_overflow !== exp_ovf) begin n_err++; $display("FAIL %s_overflow: got %b want %b", nm, out_overflow, exp_ovf); end
    n_cmp++; if (out_timeout !== 1'b0) begin n_err++; $display("FAIL %s_timeout: got %b want 0", nm, out_timeout); end
    n_cmp++; if ({out_busy, out_dem_enable} !== 2'b00) begin n_err++; $display("FAIL %s_idle: got busy/en %b want 00", nm, {out_busy, out_dem_enable}); end
  endtask

  task automatic test_reset();
    in_PoR = 1'b0; in_rx_arm = 1'b0; in_abort = 1'b0;
    in_pause = 1'b0; in_dem_bit = 1'b0; in_dem_bit_valid = 1'b0;
    repeat (4) tick();
    n_cmp++;
    if ({out_dem_enable, out_byte, out_nbits, out_byte_valid, out_byte_count, out_parity_err,
         out_overflow, out_timeout, out_busy, out_frame_done} !== 26'd0) begin
      n_err++;
      $display("FAIL reset_outputs: got %h want 0", {out_dem_enable, out_byte, out_nbits, out_byte_valid,
               out_byte_count, out_parity_err, out_overflow, out_timeout, out_busy, out_frame_done});
    end
    in_PoR = 1'b1;
    tick();
  endtask

  task automatic test_arm();
    in_rx_arm = 1'b1; tick(); in_rx_arm = 1'b0;
    n_cmp++; if (out_busy !== 1'b1) begin n_err++; $display("FAIL arm_busy: got %b want 1", out_busy); end
    n_cmp++; if (out_dem_enable !== 1'b1) begin n_err++; $display("FAIL arm_enable: got %b want 1", out_dem_enable); end
    in_abort = 1'b1; tick(); in_abort = 1'b0;
    n_cmp++; if (out_busy !== 1'b0) begin n_err++; $display("FAIL arm_abort_busy: got %b want 0", out_busy); end
  endtask

  task automatic test_short_frame();
    int base;
    tx_bits = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    base = got_q.size();
    test_frame("short", 1'b0);
    n_cmp++; if (got_q.size() <= base || got_q[base] !== 12'h726) begin n_err++; $display("FAIL short_reqa: got %h want 726", (got_q.size() > base) ? got_q[base] : 12'hxxx); end
  endtask

  task automatic test_two_bytes();
    int base;
    tx_bits.delete();
    push_byte(8'h93, 1'b1);
    push_byte(8'h20, 1'b0);
    base = got_q.size();
    test_frame("two", 1'b0);
    n_cmp++; if (got_q.size() < base + 2 || got_q[base] !== 12'h893 || got_q[base + 1] !== 12'h820) begin n_err++; $display("FAIL two_literal: got %0d strobes want 893,820", got_q.size() - base); end
    n_cmp++; if (out_byte_count !== 6'd2) begin n_err++; $display("FAIL two_count_literal: got %0d want 2", out_byte_count); end
  endtask

  task automatic test_parity_err();
    tx_bits.delete();
    push_byte(8'h93, 1'b0);
    test_frame("parity", 1'b0);
    repeat (20) tick();
    n_cmp++; if (out_parity_err !== 1'b1) begin n_err++; $display("FAIL parity_hold: got %b want 1", out_parity_err); end
    in_rx_arm = 1'b1; tick(); in_rx_arm = 1'b0;
    n_cmp++; if (out_parity_err !== 1'b0) begin n_err++; $display("FAIL parity_clear_on_arm: got %b want 0", out_parity_err); end
    n_cmp++; if (out_byte_count !== 6'd0) begin n_err++; $display("FAIL count_clear_on_arm: got %0d want 0", out_byte_count); end
    in_abort = 1'b1; tick(); in_abort = 1'b0;
  endtask

  task automatic test_eof_bit();
    int base;
    tx_bits = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    base = got_q.size();
    test_frame("eofbit", 1'b1);
    n_cmp++; if (got_q.size() <= base || got_q[base] !== 12'h726) begin n_err++; $display("FAIL eofbit_residual: got %h want 726", (got_q.size() > base) ? got_q[base] : 12'hxxx); end
  endtask

  task automatic test_timeout();
    int base, d0, w;
    bit seen;
    base = got_q.size();
    d0 = done_cnt;
    in_rx_arm = 1'b1; tick(); in_rx_arm = 1'b0;
    wait_done(4300, seen, w);
    n_cmp++; if (!seen) begin n_err++; $display("FAIL timeout_done: frame_done not seen within %0d clocks", w); end
    n_cmp++; if (out_timeout !== 1'b1) begin n_err++; $display("FAIL timeout_flag: got %b want 1", out_timeout); end
    n_cmp++; if (w < 4094 || w > 4098) begin n_err++; $display("FAIL timeout_latency: got %0d clocks want about 4096", w); end
    tick(); tick();
    n_cmp++; if (got_q.size() != base) begin n_err++; $display("FAIL timeout_nstrobes: got %0d want 0", got_q.size() - base); end
    n_cmp++; if (done_cnt - d0 != 1) begin n_err++; $display("FAIL timeout_done_pulses: got %0d want 1", done_cnt - d0); end
  endtask

  task automatic test_abort();
    int base, d0;
    tx_bits.delete();
    push_byte(8'h93, 1'b0);
    tx_bits.push_back(1'b1); tx_bits.push_back(1'b0); tx_bits.push_back(1'b1);
    base = got_q.size();
    d0 = done_cnt;
    drive_frame(1'b0);
    in_abort = 1'b1; tick(); in_abort = 1'b0;
    n_cmp++; if ({out_busy, out_dem_enable} !== 2'b00) begin n_err++; $display("FAIL abort_idle: got busy/en %b want 00", {out_busy, out_dem_enable}); end
    n_cmp++; if (out_parity_err !== 1'b1) begin n_err++; $display("FAIL abort_sticky: got %b want 1", out_parity_err); end
    repeat (150) tick();
    n_cmp++; if (done_cnt != d0) begin n_err++; $display("FAIL abort_no_done: got %0d pulses want 0", done_cnt - d0); end
    n_cmp++; if (got_q.size() != base + 1) begin n_err++; $display("FAIL abort_nstrobes: got %0d want 1", got_q.size() - base); end
    n_cmp++; if (got_q.size() <= base || got_q[base] !== 12'h893) begin n_err++; $display("FAIL abort_byte: got %h want 893", (got_q.size() > base) ? got_q[base] : 12'hxxx); end
  endtask

  task automatic test_overflow();
    logic [7:0] d;
    tx_bits.delete();
    for (int i = 0; i < 33; i++) begin
      d = 8'($urandom_range(0, 255));
      push_byte(d, ~^d);
    end
    test_frame("overflow", 1'b0);
    n_cmp++; if (out_overflow !== 1'b1) begin n_err++; $display("FAIL overflow_literal: got %b want 1", out_overflow); end
    n_cmp++; if (out_byte_count !== 6'd32) begin n_err++; $display("FAIL overflow_count_literal: got %0d want 32", out_byte_count); end
  endtask

  task automatic test_random();
    int n;
    for (int f = 0; f < 4; f++) begin
      tx_bits.delete();
      n = $urandom_range(1, 40);
      for (int i = 0; i < n; i++) tx_bits.push_back(1'($urandom_range(0, 1)));
      test_frame($sformatf("rand%0d_len%0d", f, n), 1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_arm();
    test_short_frame();
    test_two_bytes();
    test_parity_err();
    test_eof_bit();
    test_timeout();
    test_abort();
    test_overflow();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
